// File: rtl/alu_pkg.sv
// Shared types for the ALU port: data width, opcodes, requester FSM states
// and the packed response bundle captured from the ALU.
package alu_pkg;

  localparam int DATA_W = 8;

  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } req_state_t;

  typedef struct packed {
    data_t out;
    logic  negative;
    logic  overflow;
    logic  zero;
  } alu_rsp_t;

endpackage

// File: rtl/alu_if.sv
// ALU connection bundle: operands and opcode towards the ALU, result and
// flags back. The alu modport is the ALU side, requester is the initiator.
interface alu_if;
  import alu_pkg::*;

  data_t   a;
  data_t   b;
  opcode_t opcode;
  data_t   out;
  logic    negative;
  logic    overflow;
  logic    zero;

  modport alu (
    input  a, b, opcode,
    output out, negative, overflow, zero
  );

  modport requester (
    output a, b, opcode,
    input  out, negative, overflow, zero
  );

endinterface

// File: rtl/alu_requester.sv
// Single-outstanding ALU initiator: accepts a request, holds the operands on
// the ALU for ALU_LAT+1 cycles, captures the result and flags, and offers
// them on a valid/ready response channel. Every output is a register.
module alu_requester
  import alu_pkg::*;
#(
  parameter int ALU_LAT = 0,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  opcode_t            req_opcode,
  input  data_t              req_a,
  input  data_t              req_b,
  alu_if.requester           alu,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output data_t              rsp_out,
  output logic               rsp_negative,
  output logic               rsp_overflow,
  output logic               rsp_zero,
  output logic               busy,
  output logic [COUNT_W-1:0] op_count
);

  // Wait counter only needs to hold ALU_LAT; keep at least one bit so a
  // combinational ALU (ALU_LAT = 0) still gives a legal vector.
  localparam int LAT_W = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

  req_state_t       state;
  logic [LAT_W-1:0] wait_cnt;
  alu_rsp_t         rsp_q;

  assign rsp_out      = rsp_q.out;
  assign rsp_negative = rsp_q.negative;
  assign rsp_overflow = rsp_q.overflow;
  assign rsp_zero     = rsp_q.zero;

  // Request/execute/response sequencing with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      busy       <= 1'b0;
      op_count   <= '0;
      wait_cnt   <= '0;
      alu.a      <= '0;
      alu.b      <= '0;
      alu.opcode <= opcode_t'(0);
      rsp_q      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            // Operands stay on the ALU until the next accept, not just EXEC.
            alu.a      <= req_a;
            alu.b      <= req_b;
            alu.opcode <= req_opcode;
            wait_cnt   <= LAT_W'(ALU_LAT);
            req_ready  <= 1'b0;
            busy       <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          if (wait_cnt == '0) begin
            rsp_q     <= '{out:      alu.out,
                           negative: alu.negative,
                           overflow: alu.overflow,
                           zero:     alu.zero};
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt - LAT_W'(1);
          end
        end
        RESP: begin
          // No accept on the handshake edge: req_ready only rises back in IDLE.
          if (rsp_ready) begin
            op_count  <= op_count + COUNT_W'(1);
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_requester.sv
// Bench for alu_requester: one instance on a combinational ALU (ALU_LAT=0,
// COUNT_W=4) and one on a three-cycle ALU (ALU_LAT=3, COUNT_W=16), with
// results predicted from signed/bitwise arithmetic on the request operands.
module tb_alu_requester;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic    req_valid [2];
  logic    rsp_ready [2];
  opcode_t req_opcode [2];
  data_t   req_a [2];
  data_t   req_b [2];
  logic    req_ready [2];
  logic    rsp_valid [2];
  data_t   rsp_out [2];
  logic    rsp_negative [2];
  logic    rsp_overflow [2];
  logic    rsp_zero [2];
  logic    busy [2];
  logic [3:0]  cnt0;
  logic [15:0] cnt1;
  data_t   mon_a [2];
  data_t   mon_b [2];
  opcode_t mon_op [2];

  int checks = 0;
  int passed = 0;
  int exp_cnt [2];
  int last_accept = 0;
  int last_interval = 0;

  // Behavioural ALU: signed add/sub with overflow when the true result leaves
  // the 8-bit signed range, bitwise ops never overflow.
  function automatic alu_rsp_t alu_ref(opcode_t op, data_t a, data_t b);
    int sa, sb, r;
    alu_rsp_t res;
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (op)
      OP_ADD:  r = sa + sb;
      OP_SUB:  r = sa - sb;
      OP_AND:  r = int'(a & b);
      OP_OR:   r = int'(a | b);
      OP_XOR:  r = int'(a ^ b);
      default: r = 0;
    endcase
    res.out      = data_t'(r);
    res.overflow = (op == OP_ADD || op == OP_SUB) && (r > 127 || r < -128);
    res.negative = res.out[DATA_W-1];
    res.zero     = (res.out == 8'h00);
    return res;
  endfunction

  alu_if bus0 ();
  alu_if bus1 ();

  alu_rsp_t r0, s1, s2;
  assign r0 = alu_ref(bus0.opcode, bus0.a, bus0.b);
  assign bus0.out      = r0.out;
  assign bus0.negative = r0.negative;
  assign bus0.overflow = r0.overflow;
  assign bus0.zero     = r0.zero;

  // Slow ALU: result is only correct once operands have been held 3 cycles.
  always @(posedge clk) begin
    s1 <= alu_ref(bus1.opcode, bus1.a, bus1.b);
    s2 <= s1;
  end
  assign bus1.out      = s2.out;
  assign bus1.negative = s2.negative;
  assign bus1.overflow = s2.overflow;
  assign bus1.zero     = s2.zero;

  assign mon_a[0] = bus0.a;
  assign mon_b[0] = bus0.b;
  assign mon_op[0] = bus0.opcode;
  assign mon_a[1] = bus1.a;
  assign mon_b[1] = bus1.b;
  assign mon_op[1] = bus1.opcode;

  alu_requester #(.ALU_LAT(0), .COUNT_W(4)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_opcode(req_opcode[0]), .req_a(req_a[0]), .req_b(req_b[0]),
    .alu(bus0),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_out(rsp_out[0]), .rsp_negative(rsp_negative[0]),
    .rsp_overflow(rsp_overflow[0]), .rsp_zero(rsp_zero[0]),
    .busy(busy[0]), .op_count(cnt0)
  );

  alu_requester #(.ALU_LAT(3), .COUNT_W(16)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_opcode(req_opcode[1]), .req_a(req_a[1]), .req_b(req_b[1]),
    .alu(bus1),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_out(rsp_out[1]), .rsp_negative(rsp_negative[1]),
    .rsp_overflow(rsp_overflow[1]), .rsp_zero(rsp_zero[1]),
    .busy(busy[1]), .op_count(cnt1)
  );

  function automatic int get_cnt(int d);
    return (d == 0) ? int'(cnt0) : int'(cnt1);
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_idle_reset(int d);
    check("rst_req_ready", 32'(req_ready[d]), 32'(1));
    check("rst_rsp_valid", 32'(rsp_valid[d]), 32'(0));
    check("rst_busy", 32'(busy[d]), 32'(0));
    check("rst_op_count", get_cnt(d), 0);
  endtask

  // One complete transaction on instance d, called just after a falling edge.
  // hold = response cycles with rsp_ready low; keep = req_valid stays high.
  task automatic run_op(int d, opcode_t op, data_t a, data_t b, int hold, bit keep);
    alu_rsp_t e;
    int lat, n, c0;
    e   = alu_ref(op, a, b);
    lat = (d == 0) ? 0 : 3;
    c0  = exp_cnt[d];
    check("idle_ready", 32'(req_ready[d]), 32'(1));
    req_valid[d]  = 1'b1;
    req_opcode[d] = op;
    req_a[d]      = a;
    req_b[d]      = b;
    rsp_ready[d]  = (hold == 0);
    last_interval = cyc + 1 - last_accept;
    last_accept   = cyc + 1;
    @(negedge clk);
    req_valid[d] = keep;
    req_a[d]     = ~a;
    n = 0;
    while (rsp_valid[d] !== 1'b1 && n < 20) begin
      check("exec_alu_a", 32'(mon_a[d]), 32'(a));
      check("exec_alu_b", 32'(mon_b[d]), 32'(b));
      check("exec_alu_op", 32'(mon_op[d]), 32'(op));
      check("exec_busy", 32'(busy[d]), 32'(1));
      check("exec_req_ready", 32'(req_ready[d]), 32'(0));
      @(negedge clk);
      n++;
    end
    check("rsp_latency", n, lat + 1);
    check("rsp_out", 32'(rsp_out[d]), 32'(e.out));
    check("rsp_negative", 32'(rsp_negative[d]), 32'(e.negative));
    check("rsp_overflow", 32'(rsp_overflow[d]), 32'(e.overflow));
    check("rsp_zero", 32'(rsp_zero[d]), 32'(e.zero));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", 32'(rsp_valid[d]), 32'(1));
      check("bp_rsp_out", 32'(rsp_out[d]), 32'(e.out));
      check("bp_flags", 32'({rsp_negative[d], rsp_overflow[d], rsp_zero[d]}),
            32'({e.negative, e.overflow, e.zero}));
      check("bp_req_ready", 32'(req_ready[d]), 32'(0));
      check("bp_op_count", get_cnt(d), c0);
    end
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    exp_cnt[d] = (d == 0) ? (c0 + 1) % 16 : (c0 + 1) % 65536;
    check("done_rsp_valid", 32'(rsp_valid[d]), 32'(0));
    check("done_busy", 32'(busy[d]), 32'(0));
    check("done_req_ready", 32'(req_ready[d]), 32'(1));
    check("done_op_count", get_cnt(d), exp_cnt[d]);
    check("done_alu_a_held", 32'(mon_a[d]), 32'(a));
    req_valid[d] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d]  = 1'b0;
      rsp_ready[d]  = 1'b0;
      req_opcode[d] = OP_ADD;
      req_a[d]      = 8'h00;
      req_b[d]      = 8'h00;
      exp_cnt[d]    = 0;
    end
    repeat (3) @(negedge clk);

    // Reset values on both instances.
    for (int d = 0; d < 2; d++) begin
      check_idle_reset(d);
      check("rst_alu_a", 32'(mon_a[d]), 32'(0));
      check("rst_alu_b", 32'(mon_b[d]), 32'(0));
      check("rst_alu_op", 32'(mon_op[d]), 32'(0));
      check("rst_rsp_out", 32'(rsp_out[d]), 32'(0));
      check("rst_rsp_flags", 32'({rsp_negative[d], rsp_overflow[d], rsp_zero[d]}), 32'(0));
    end
    rst = 1'b0;
    @(negedge clk);

    // Combinational ALU, 0x7F + 0x01 wraps negative with overflow.
    run_op(0, OP_ADD, 8'h7F, 8'h01, 0, 1'b0);
    check("t1_out", 32'(rsp_out[0]), 32'h80);
    check("t1_flags", 32'({rsp_negative[0], rsp_overflow[0], rsp_zero[0]}), 32'(3'b110));

    // Three-cycle ALU, 5 - 5 gives zero.
    run_op(1, OP_SUB, 8'h05, 8'h05, 0, 1'b0);
    check("t2_out", 32'(rsp_out[1]), 32'h00);
    check("t2_zero", 32'(rsp_zero[1]), 32'(1));

    // Backpressure with a new request pending the whole time.
    run_op(1, OP_ADD, data_t'($urandom), data_t'($urandom), 5, 1'b1);

    // Reset in the middle of EXEC discards the operation.
    req_valid[1]  = 1'b1;
    req_opcode[1] = OP_ADD;
    req_a[1]      = 8'h03;
    req_b[1]      = 8'h04;
    @(negedge clk);
    req_valid[1] = 1'b0;
    check("t4_busy_exec", 32'(busy[1]), 32'(1));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
    check_idle_reset(1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t4_no_rsp", 32'({rsp_valid[1], busy[1]}), 32'(0));
    end
    check("t4_op_count", get_cnt(1), 0);

    // Randomized operations on both instances with random backpressure.
    for (int i = 0; i < 12; i++) begin
      run_op(i % 2, opcode_t'($urandom_range(0, 4)), data_t'($urandom),
             data_t'($urandom), int'($urandom_range(0, 3)), 1'b0);
    end
    run_op(0, OP_XOR, 8'h5A, 8'h5A, 1, 1'b0);
    run_op(1, OP_SUB, 8'h80, 8'h01, 2, 1'b0);

    // Counter wrap and issue interval with rsp_ready held high.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
    rsp_ready[0] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      run_op(0, opcode_t'($urandom_range(0, 4)), data_t'($urandom),
             data_t'($urandom), 0, 1'b0);
      if (i > 0) check("t5_interval", last_interval, 3);
      if (i == 14) check("t5_count15", 32'(cnt0), 32'd15);
      if (i == 15) check("t5_count_wrap", 32'(cnt0), 32'd0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
